ccc_initiator: RTL

Controller-side Common Command Code (CCC) sequencer. It accepts one CCC request at a time, either broadcast or direct, and breaks it into byte-level bus operations for the I3C bit engine: START, 0x7E/W, command code, optional defining byte, data phase, and Sr, target address and data for direct CCCs. It then terminates the transfer with STOP, or leaves the bus in HDR for ENTHDR0. It sits between the command-queue executor and the SCL/SDA bit engine, and is the initiator counterpart to the target-side CCC decoder.

---
 rtl/ccc_initiator.sv | 357 +++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/ccc_initiator.sv
// ccc_initiator: controller-side CCC sequencer.
// Breaks one broadcast or direct CCC request into byte-level bus operations
// for the I3C bit engine. At most one engine op is outstanding at any time.
module ccc_initiator #(
    parameter int LenW = 4
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            ccc_valid_i,
    output logic            ccc_ready_o,
    input  logic [7:0]      ccc_code_i,
    input  logic [7:0]      def_byte_i,
    input  logic            def_byte_en_i,
    input  logic [6:0]      tgt_addr_i,
    input  logic            tgt_rnw_i,
    input  logic [LenW-1:0] len_i,
    input  logic [7:0]      wdata_i,
    input  logic            wdata_valid_i,
    output logic            wdata_ready_o,
    output logic [7:0]      rdata_o,
    output logic            rdata_valid_o,
    output logic [2:0]      op_o,
    output logic [7:0]      op_byte_o,
    output logic            op_last_o,
    output logic            op_valid_o,
    input  logic            op_ready_i,
    input  logic            op_done_i,
    input  logic            op_nack_i,
    input  logic [7:0]      op_rdata_i,
    input  logic            op_eot_i,
    output logic            done_o,
    output logic [1:0]      status_o,
    output logic [LenW-1:0] xfer_cnt_o,
    output logic            hdr_entered_o
);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_START = 4'd1,
        S_BADDR = 4'd2,
        S_CODE  = 4'd3,
        S_DEFB  = 4'd4,
        S_BDATA = 4'd5,
        S_SR    = 4'd6,
        S_TADDR = 4'd7,
        S_DWR   = 4'd8,
        S_DRD   = 4'd9,
        S_STOP  = 4'd10,
        S_DONE  = 4'd11
    } state_e;

    localparam logic [2:0] OP_START  = 3'd0;
    localparam logic [2:0] OP_SR     = 3'd1;
    localparam logic [2:0] OP_ADDR   = 3'd2;
    localparam logic [2:0] OP_WRBYTE = 3'd3;
    localparam logic [2:0] OP_RDBYTE = 3'd4;
    localparam logic [2:0] OP_STOP   = 3'd5;

    localparam logic [1:0] ST_OK       = 2'd0;
    localparam logic [1:0] ST_BC_NACK  = 2'd1;
    localparam logic [1:0] ST_TGT_NACK = 2'd2;
    localparam logic [1:0] ST_EARLY    = 2'd3;

    localparam logic [7:0] BCAST_WR  = 8'hFC;  // 0x7E with W
    localparam logic [7:0] CC_ENTHDR0 = 8'h20;
    localparam logic [LenW-1:0] CNT_ONE  = {{(LenW-1){1'b0}}, 1'b1};
    localparam logic [LenW-1:0] CNT_ZERO = {LenW{1'b0}};

    state_e          state_q, state_d;
    logic            wait_q, wait_d;          // op accepted, awaiting op_done_i
    logic [7:0]      code_q, code_d;
    logic [7:0]      defb_q, defb_d;
    logic            defb_en_q, defb_en_d;
    logic [6:0]      addr_q, addr_d;
    logic            rnw_q, rnw_d;
    logic [LenW-1:0] len_q, len_d;
    logic [LenW-1:0] cnt_q, cnt_d;
    logic [1:0]      status_q, status_d;
    logic            hdr_q, hdr_d;
    logic            op_valid_q, op_valid_d;
    logic [2:0]      op_q, op_d;
    logic [7:0]      op_byte_q, op_byte_d;
    logic            op_last_q, op_last_d;
    logic [7:0]      rdata_q, rdata_d;
    logic            rdata_valid_q, rdata_valid_d;
    logic            done_q, done_d;
    logic            ready_q, ready_d;

    state_e          next_phase_s;
    logic [LenW-1:0] cnt_inc_s;
    logic            start_op_s;
    logic            data_state_s;

    // Phase that follows the command code / defining byte.
    always_comb begin
        if (code_q[7]) begin
            next_phase_s = S_SR;
        end else if (len_q != CNT_ZERO) begin
            next_phase_s = S_BDATA;
        end else begin
            next_phase_s = S_STOP;
        end
    end

    assign cnt_inc_s    = cnt_q + CNT_ONE;
    assign data_state_s = (state_q == S_BDATA) || (state_q == S_DWR);

    // Next-state, counter, status and op-issue logic.
    always_comb begin
        state_d       = state_q;
        wait_d        = wait_q;
        code_d        = code_q;
        defb_d        = defb_q;
        defb_en_d     = defb_en_q;
        addr_d        = addr_q;
        rnw_d         = rnw_q;
        len_d         = len_q;
        cnt_d         = cnt_q;
        status_d      = status_q;
        hdr_d         = hdr_q;
        op_valid_d    = op_valid_q;
        op_d          = op_q;
        op_byte_d     = op_byte_q;
        op_last_d     = op_last_q;
        rdata_d       = rdata_q;
        rdata_valid_d = 1'b0;
        start_op_s    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (ccc_valid_i) begin
                    code_d     = ccc_code_i;
                    defb_d     = def_byte_i;
                    defb_en_d  = def_byte_en_i;
                    addr_d     = tgt_addr_i;
                    rnw_d      = tgt_rnw_i;
                    len_d      = len_i;
                    cnt_d      = CNT_ZERO;
                    status_d   = ST_OK;
                    wait_d     = 1'b0;
                    state_d    = S_START;
                    start_op_s = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                if (op_valid_q) begin
                    // op_done_i in the handshake cycle is ignored
                    if (op_ready_i) begin
                        op_valid_d = 1'b0;
                        wait_d     = 1'b1;
                    end else begin
                        op_valid_d = 1'b1;
                    end
                end else if (wait_q) begin
                    if (op_done_i) begin
                        wait_d     = 1'b0;
                        start_op_s = 1'b1;
                        case (state_q)
                            S_START: state_d = S_BADDR;
                            S_BADDR: begin
                                if (op_nack_i) begin
                                    status_d = ST_BC_NACK;
                                    state_d  = S_STOP;
                                end else begin
                                    state_d = S_CODE;
                                end
                            end
                            S_CODE: begin
                                if (code_q == CC_ENTHDR0) begin
                                    hdr_d   = 1'b1;
                                    state_d = S_DONE;
                                end else if (defb_en_q) begin
                                    state_d = S_DEFB;
                                end else begin
                                    state_d = next_phase_s;
                                end
                            end
                            S_DEFB: state_d = next_phase_s;
                            S_SR:   state_d = S_TADDR;
                            S_TADDR: begin
                                if (op_nack_i) begin
                                    status_d = ST_TGT_NACK;
                                    state_d  = S_STOP;
                                end else if (len_q == CNT_ZERO) begin
                                    state_d = S_STOP;
                                end else if (rnw_q) begin
                                    state_d = S_DRD;
                                end else begin
                                    state_d = S_DWR;
                                end
                            end
                            S_BDATA, S_DWR: begin
                                cnt_d = cnt_inc_s;
                                if (cnt_inc_s == len_q) begin
                                    state_d = S_STOP;
                                end else begin
                                    state_d = state_q;
                                end
                            end
                            S_DRD: begin
                                cnt_d         = cnt_inc_s;
                                rdata_d       = op_rdata_i;
                                rdata_valid_d = 1'b1;
                                if (op_eot_i && (cnt_inc_s < len_q)) begin
                                    status_d = ST_EARLY;
                                    state_d  = S_STOP;
                                end else if (cnt_inc_s == len_q) begin
                                    state_d = S_STOP;
                                end else begin
                                    state_d = S_DRD;
                                end
                            end
                            S_STOP:  state_d = S_DONE;
                            default: state_d = S_IDLE;
                        endcase
                    end else begin
                        wait_d = 1'b1;
                    end
                end else begin
                    // not yet issued: data phases wait here for write data
                    start_op_s = 1'b1;
                end
            end
        endcase

        if (start_op_s) begin
            case (state_d)
                S_START: begin
                    op_valid_d = 1'b1;
                    op_d       = OP_START;
                    op_byte_d  = 8'h00;
                    op_last_d  = 1'b0;
                end
                S_BADDR: begin
                    op_valid_d = 1'b1;
                    op_d       = OP_ADDR;
                    op_byte_d  = BCAST_WR;
                    op_last_d  = 1'b0;
                end
                S_CODE: begin
                    op_valid_d = 1'b1;
                    op_d       = OP_WRBYTE;
                    op_byte_d  = code_q;
                    op_last_d  = 1'b0;
                end
                S_DEFB: begin
                    op_valid_d = 1'b1;
                    op_d       = OP_WRBYTE;
                    op_byte_d  = defb_q;
                    op_last_d  = 1'b0;
                end
                S_BDATA, S_DWR: begin
                    op_valid_d = wdata_valid_i;
                    op_d       = OP_WRBYTE;
                    op_byte_d  = wdata_i;
                    op_last_d  = 1'b0;
                end
                S_SR: begin
                    op_valid_d = 1'b1;
                    op_d       = OP_SR;
                    op_byte_d  = 8'h00;
                    op_last_d  = 1'b0;
                end
                S_TADDR: begin
                    op_valid_d = 1'b1;
                    op_d       = OP_ADDR;
                    op_byte_d  = {addr_q, rnw_q};
                    op_last_d  = 1'b0;
                end
                S_DRD: begin
                    op_valid_d = 1'b1;
                    op_d       = OP_RDBYTE;
                    op_byte_d  = 8'h00;
                    op_last_d  = (cnt_d == (len_q - CNT_ONE));
                end
                S_STOP: begin
                    op_valid_d = 1'b1;
                    op_d       = OP_STOP;
                    op_byte_d  = 8'h00;
                    op_last_d  = 1'b0;
                end
                default: begin
                    op_valid_d = 1'b0;
                end
            endcase
        end else begin
            start_op_s = 1'b0;
        end

        done_d  = (state_d == S_DONE);
        ready_d = (state_d == S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= S_IDLE;
            wait_q        <= 1'b0;
            code_q        <= 8'h00;
            defb_q        <= 8'h00;
            defb_en_q     <= 1'b0;
            addr_q        <= 7'h00;
            rnw_q         <= 1'b0;
            len_q         <= CNT_ZERO;
            cnt_q         <= CNT_ZERO;
            status_q      <= ST_OK;
            hdr_q         <= 1'b0;
            op_valid_q    <= 1'b0;
            op_q          <= OP_START;
            op_byte_q     <= 8'h00;
            op_last_q     <= 1'b0;
            rdata_q       <= 8'h00;
            rdata_valid_q <= 1'b0;
            done_q        <= 1'b0;
            ready_q       <= 1'b1;
        end else begin
            state_q       <= state_d;
            wait_q        <= wait_d;
            code_q        <= code_d;
            defb_q        <= defb_d;
            defb_en_q     <= defb_en_d;
            addr_q        <= addr_d;
            rnw_q         <= rnw_d;
            len_q         <= len_d;
            cnt_q         <= cnt_d;
            status_q      <= status_d;
            hdr_q         <= hdr_d;
            op_valid_q    <= op_valid_d;
            op_q          <= op_d;
            op_byte_q     <= op_byte_d;
            op_last_q     <= op_last_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
            done_q        <= done_d;
            ready_q       <= ready_d;
        end
    end

    assign ccc_ready_o   = ready_q;
    assign wdata_ready_o = op_valid_q & op_ready_i & data_state_s;
    assign rdata_o       = rdata_q;
    assign rdata_valid_o = rdata_valid_q;
    assign op_o          = op_q;
    assign op_byte_o     = op_byte_q;
    assign op_last_o     = op_last_q;
    assign op_valid_o    = op_valid_q;
    assign done_o        = done_q;
    assign status_o      = status_q;
    assign xfer_cnt_o    = cnt_q;
    assign hdr_entered_o = hdr_q;

endmodule
